mii_rx_nibble: RTL and testbench
================================

MII_RX_NIBBLE -- requirements
Module: mii_rx_nibble

Interface
REQ-001 Parameter: none; all limits fixed in this document.
REQ-002 rx_clock_i  in  1  MII receive clock (2.5/25 MHz); the only clock.
REQ-003 rx_reset_i  in  1  reset, asynchronous, active-high.
REQ-004 phy_rx_dv_i  in  1  PHY RX_DV.
REQ-005 phy_rxd_i  in  4  PHY RXD; the low nibble of each byte arrives first.
REQ-006 phy_rx_er_i  in  1  PHY RX_ER.
REQ-007 mii_rx_frame_o  out  1  frame in progress; feeds the framing layer's mii_rx_frame_i.
REQ-008 mii_rx_data_o  out  8  assembled byte; valid only while mii_rx_byte_received_o=1.
REQ-009 mii_rx_byte_received_o  out  1  one-cycle pulse per assembled byte.
REQ-010 mii_rx_error_o  out  1  frame error flag.
REQ-011 dribble_o  out  1  one-cycle pulse: frame ended on an odd nibble.
REQ-012 false_carrier_o  out  1  one-cycle pulse: false carrier detected.
REQ-013 frame_count_o  out  16  frames started (SFD seen); wraps 0xFFFF->0.
REQ-014 error_count_o  out  16  frames with error_o set, plus false carriers; saturates at 0xFFFF.

Function
REQ-015 All outputs SHALL be registered; PHY inputs SHALL be sampled on the rising edge of rx_clock_i; each output responds to the sample taken 1 cycle earlier.
REQ-016 States SHALL be IDLE, PREAMBLE, LOW, HIGH and DRAIN.
REQ-017 IDLE: dv=1 with nibble 0x5 SHALL go to PREAMBLE; dv=1 with any other nibble SHALL go to DRAIN.
REQ-018 IDLE: dv=0, er=1, rxd=0xE SHALL pulse false_carrier_o and increment error_count_o; state remains IDLE.
REQ-019 PREAMBLE: nibble 0x5 SHALL stay in PREAMBLE, with no length limit.
REQ-020 PREAMBLE: nibble 0xD SHALL emit byte 0xD5, pulse byte_received, assert frame_o, increment frame_count_o and go to LOW.
REQ-021 PREAMBLE: any other nibble, or er=1, SHALL go to DRAIN.
REQ-022 LOW: SHALL latch the nibble and go to HIGH.
REQ-023 HIGH: SHALL emit {nibble, latched_low}, pulse byte_received and go to LOW.
REQ-024 DRAIN: SHALL hold frame_o=1 and error_o=1, SHALL emit no byte pulses, and SHALL go to IDLE on dv=0.
REQ-025 dv=0 sampled in LOW/HIGH/PREAMBLE: frame_o SHALL drop on the next output cycle and state SHALL return to IDLE.
REQ-026 dv=0 in HIGH (one nibble latched, odd count): the nibble SHALL be discarded with no byte pulse, dribble_o SHALL pulse, and error_o SHALL be unaffected.
REQ-027 er=1 with dv=1 in LOW/HIGH: error_o SHALL set; byte assembly SHALL continue unchanged.
REQ-028 error_o is sticky: it SHALL stay high while frame_o=1 and through the first cycle with frame_o=0, then clear.
REQ-029 error_count_o SHALL increment once per frame whose error_o was set, at frame end; a DRAIN episode counts as one frame error.
REQ-030 Simultaneous er=1 and dv falling SHALL produce error_o=1 on the frame_o-falling cycle.
REQ-031 dv rising in the cycle immediately after a frame ends SHALL start a new frame normally; no idle gap is required.
REQ-032 mii_rx_data_o SHALL hold its last value when byte_received=0.

Reset
REQ-033 While rx_reset_i=1: state=IDLE; frame_o, byte_received_o, error_o, dribble_o and false_carrier_o=0; data_o=0x00; both counters=0.
REQ-034 Reset asserted mid-frame SHALL drop frame_o immediately (asynchronously), SHALL NOT count the frame as an error, and SHALL discard the partial byte.
REQ-035 After reset release while dv=1, the block SHALL go to DRAIN unless the first sampled nibble is 0x5.

Verification
REQ-036 Preamble of 15x 0x5, then 0xD, then nibbles 1,2,3,4 -> bytes 0xD5, 0x21, 0x43 each pulsed once; frame_o high from the 0xD5 pulse; frame_count_o=1; error_o=0.
REQ-037 Same frame with er=1 on the 2nd data nibble -> error_o rises 1 cycle later, stays high through the first frame_o=0 cycle, then clears; error_count_o=1.
REQ-038 Frame ending after 3 data nibbles -> one data byte, dribble_o pulses once, no extra byte_received, error_o=0.
REQ-039 dv=1 with first nibble 0xA -> frame_o=1 and error_o=1 and no byte pulses until dv falls; error_count_o=1; frame_count_o unchanged.
REQ-040 dv=0, er=1, rxd=0xE for 1 cycle -> false_carrier_o pulses once; error_count_o increments; frame_o stays 0.
REQ-041 Preset error_count_o to 0xFFFF via 65535 bad frames, then one more bad frame -> stays 0xFFFF; frame_count_o at 0xFFFF plus one good frame -> 0x0000.

Source files
------------

// File: rtl/mii_rx_nibble_if.sv
// Signal bundle between the MII PHY receive pins and the nibble-to-byte assembler.
// The slave modport is the assembler's view; the master modport drives the PHY side.
interface mii_rx_nibble_if;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              phy_rx_dv_i;
  logic [NIB_W-1:0]  phy_rxd_i;
  logic              phy_rx_er_i;

  logic              mii_rx_frame_o;
  logic [BYTE_W-1:0] mii_rx_data_o;
  logic              mii_rx_byte_received_o;
  logic              mii_rx_error_o;
  logic              dribble_o;
  logic              false_carrier_o;
  logic [CNT_W-1:0]  frame_count_o;
  logic [CNT_W-1:0]  error_count_o;

  modport master (
    output phy_rx_dv_i, phy_rxd_i, phy_rx_er_i,
    input  mii_rx_frame_o, mii_rx_data_o, mii_rx_byte_received_o, mii_rx_error_o,
    input  dribble_o, false_carrier_o, frame_count_o, error_count_o
  );

  modport slave (
    input  phy_rx_dv_i, phy_rxd_i, phy_rx_er_i,
    output mii_rx_frame_o, mii_rx_data_o, mii_rx_byte_received_o, mii_rx_error_o,
    output dribble_o, false_carrier_o, frame_count_o, error_count_o
  );
endinterface

// File: rtl/mii_rx_nibble.sv
// MII receive front end: strips the preamble, pairs nibbles (low first) into bytes,
// flags frame errors, dribble nibbles and false carriers, and keeps frame/error counts.
module mii_rx_nibble (
  input  logic           rx_clock_i,
  input  logic           rx_reset_i,
  mii_rx_nibble_if.slave mii
);
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [NIB_W-1:0]  NIB_PRE  = 4'h5;
  localparam logic [NIB_W-1:0]  NIB_SFD  = 4'hD;
  localparam logic [NIB_W-1:0]  NIB_FC   = 4'hE;
  localparam logic [BYTE_W-1:0] BYTE_SFD = 8'hD5;
  localparam logic [CNT_W-1:0]  CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_LOW      = 3'd2,
    ST_HIGH     = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               frame_q, frame_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               byte_q, byte_d;
  logic               error_q, error_d;
  logic               dribble_q, dribble_d;
  logic               fc_q, fc_d;
  logic [NIB_W-1:0]   low_q, low_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic [CNT_W-1:0]   error_count_q, error_count_d;
  logic               err_inc_c;

  logic              dv;
  logic              er;
  logic [NIB_W-1:0]  rxd;

  assign dv  = mii.phy_rx_dv_i;
  assign er  = mii.phy_rx_er_i;
  assign rxd = mii.phy_rxd_i;

  // Next state and next registered outputs from the current state and PHY sample.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    data_d        = data_q;
    byte_d        = 1'b0;
    error_d       = error_q;
    dribble_d     = 1'b0;
    fc_d          = 1'b0;
    low_d         = low_q;
    frame_count_d = frame_count_q;
    err_inc_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // error_o lingers one cycle past frame end, then clears here
        frame_d = 1'b0;
        error_d = 1'b0;
        if (dv) begin
          if (rxd == NIB_PRE) begin
            state_d = ST_PREAMBLE;
          end else begin
            state_d = ST_DRAIN;
            frame_d = 1'b1;
            error_d = 1'b1;
          end
        end else if (er && (rxd == NIB_FC)) begin
          fc_d      = 1'b1;
          err_inc_c = 1'b1;
        end
      end

      ST_PREAMBLE: begin
        frame_d = 1'b0;
        error_d = 1'b0;
        if (!dv) begin
          state_d = ST_IDLE;
        end else if (er) begin
          state_d = ST_DRAIN;
          frame_d = 1'b1;
          error_d = 1'b1;
        end else if (rxd == NIB_PRE) begin
          state_d = ST_PREAMBLE;
        end else if (rxd == NIB_SFD) begin
          state_d       = ST_LOW;
          frame_d       = 1'b1;
          byte_d        = 1'b1;
          data_d        = BYTE_SFD;
          frame_count_d = frame_count_q + CNT_W'(1);
        end else begin
          state_d = ST_DRAIN;
          frame_d = 1'b1;
          error_d = 1'b1;
        end
      end

      ST_LOW: begin
        error_d = error_q | er;
        if (!dv) begin
          state_d   = ST_IDLE;
          frame_d   = 1'b0;
          err_inc_c = error_q | er;
        end else begin
          state_d = ST_HIGH;
          low_d   = rxd;
        end
      end

      ST_HIGH: begin
        error_d = error_q | er;
        if (!dv) begin
          // odd nibble count: drop the half byte and flag it
          state_d   = ST_IDLE;
          frame_d   = 1'b0;
          dribble_d = 1'b1;
          err_inc_c = error_q | er;
        end else begin
          state_d = ST_LOW;
          byte_d  = 1'b1;
          data_d  = {rxd, low_q};
        end
      end

      ST_DRAIN: begin
        frame_d = 1'b1;
        error_d = 1'b1;
        if (!dv) begin
          state_d   = ST_IDLE;
          frame_d   = 1'b0;
          err_inc_c = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        frame_d = 1'b0;
        error_d = 1'b0;
      end
    endcase

    error_count_d = (err_inc_c && (error_count_q != CNT_MAX))
                  ? error_count_q + CNT_W'(1) : error_count_q;
  end

  // State and output registers.
  always_ff @(posedge rx_clock_i or posedge rx_reset_i) begin
    if (rx_reset_i) begin
      state_q       <= ST_IDLE;
      frame_q       <= 1'b0;
      data_q        <= '0;
      byte_q        <= 1'b0;
      error_q       <= 1'b0;
      dribble_q     <= 1'b0;
      fc_q          <= 1'b0;
      low_q         <= '0;
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      data_q        <= data_d;
      byte_q        <= byte_d;
      error_q       <= error_d;
      dribble_q     <= dribble_d;
      fc_q          <= fc_d;
      low_q         <= low_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign mii.mii_rx_frame_o         = frame_q;
  assign mii.mii_rx_data_o          = data_q;
  assign mii.mii_rx_byte_received_o = byte_q;
  assign mii.mii_rx_error_o         = error_q;
  assign mii.dribble_o              = dribble_q;
  assign mii.false_carrier_o        = fc_q;
  assign mii.frame_count_o          = frame_count_q;
  assign mii.error_count_o          = error_count_q;

endmodule

// File: tb/tb_mii_rx_nibble.sv
// Bench for mii_rx_nibble: directed PHY episodes checked cycle by cycle against an
// episode-level model, plus literal expectations on bytes and counters.
module tb_mii_rx_nibble;
  typedef struct packed {
    logic       dv;
    logic       er;
    logic [3:0] rxd;
  } smp_t;

  typedef struct packed {
    logic        frame;
    logic        byte_v;
    logic [7:0]  data;
    logic        error;
    logic        dribble;
    logic        fc;
    logic [15:0] fcnt;
    logic [15:0] ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  mii_rx_nibble_if bus ();

  mii_rx_nibble dut (
    .rx_clock_i (clk),
    .rx_reset_i (rst),
    .mii        (bus)
  );

  always #5 clk = ~clk;

  smp_t        ep[$];
  exp_t        exq[$];
  logic [7:0]  got[$];
  logic [7:0]  want[$];
  int          n_drib;
  int          n_fc;
  logic [7:0]  m_data;
  logic [15:0] m_fcnt;
  logic [15:0] m_ecnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic add(input logic dv, input logic er, input logic [3:0] rxd);
    smp_t s;
    s.dv = dv; s.er = er; s.rxd = rxd;
    ep.push_back(s);
  endtask

  task automatic nib(input logic [3:0] n);
    add(1'b1, 1'b0, n);
  endtask

  task automatic idle(input int n);
    repeat (n) add(1'b0, 1'b0, 4'h0);
  endtask

  // Expected outputs for one episode: a dv=1 run followed by dv=0 samples, from IDLE.
  task automatic model_episode();
    int   n, len, p, d;
    logic acc;
    exp_t e;
    n = ep.size(); len = 0; p = -1; d = -1; acc = 1'b0;
    while (len < n && ep[len].dv) len++;
    if (len > 0) begin
      if (ep[0].rxd != 4'h5) d = 0;
      else
        for (int j = 1; j < len; j++)
          if (p < 0 && d < 0 && (ep[j].er || ep[j].rxd != 4'h5)) begin
            if (!ep[j].er && ep[j].rxd == 4'hD) p = j;
            else d = j;
          end
    end
    exq.delete();
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (d >= 0 && i >= d && i < len) begin
        e.frame = 1'b1; e.error = 1'b1;
      end else if (d >= 0 && i == len) begin
        e.error = 1'b1; m_ecnt = sat_inc(m_ecnt);
      end else if (p >= 0 && i == p) begin
        e.frame = 1'b1; e.byte_v = 1'b1; m_data = 8'hD5; m_fcnt = m_fcnt + 16'd1;
      end else if (p >= 0 && i > p && i <= len) begin
        acc     = acc | ep[i].er;
        e.error = acc;
        if (i < len) begin
          e.frame = 1'b1;
          if (((i - p) % 2) == 0) begin
            e.byte_v = 1'b1;
            m_data   = {ep[i].rxd, ep[i-1].rxd};
          end
        end else begin
          e.dribble = (((len - 1 - p) % 2) == 1);
          if (acc) m_ecnt = sat_inc(m_ecnt);
        end
      end else if (len == 0 || i > len) begin
        if (!ep[i].dv && ep[i].er && ep[i].rxd == 4'hE) begin
          e.fc = 1'b1; m_ecnt = sat_inc(m_ecnt);
        end
      end
      e.data = m_data; e.fcnt = m_fcnt; e.ecnt = m_ecnt;
      exq.push_back(e);
    end
  endtask

  task automatic compare(input string tag, input int i, input exp_t e);
    chk($sformatf("%s[%0d].frame", tag, i),   32'(bus.mii_rx_frame_o),         32'(e.frame));
    chk($sformatf("%s[%0d].byte", tag, i),    32'(bus.mii_rx_byte_received_o), 32'(e.byte_v));
    chk($sformatf("%s[%0d].data", tag, i),    32'(bus.mii_rx_data_o),          32'(e.data));
    chk($sformatf("%s[%0d].error", tag, i),   32'(bus.mii_rx_error_o),         32'(e.error));
    chk($sformatf("%s[%0d].dribble", tag, i), 32'(bus.dribble_o),              32'(e.dribble));
    chk($sformatf("%s[%0d].fc", tag, i),      32'(bus.false_carrier_o),        32'(e.fc));
    chk($sformatf("%s[%0d].fcnt", tag, i),    32'(bus.frame_count_o),          32'(e.fcnt));
    chk($sformatf("%s[%0d].ecnt", tag, i),    32'(bus.error_count_o),          32'(e.ecnt));
  endtask

  // Called at a negedge; drives each sample, checks the response after the next posedge.
  task automatic run_episode(input string tag);
    model_episode();
    got.delete(); n_drib = 0; n_fc = 0;
    for (int i = 0; i < ep.size(); i++) begin
      bus.phy_rx_dv_i = ep[i].dv;
      bus.phy_rx_er_i = ep[i].er;
      bus.phy_rxd_i   = ep[i].rxd;
      @(posedge clk); #1;
      compare(tag, i, exq[i]);
      if (bus.mii_rx_byte_received_o) got.push_back(bus.mii_rx_data_o);
      if (bus.dribble_o) n_drib++;
      if (bus.false_carrier_o) n_fc++;
      @(negedge clk);
    end
    ep.delete();
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, ".nbytes"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i), 32'(got[i]), 32'(want[i]));
  endtask

  task automatic drive(input logic dv, input logic er, input logic [3:0] rxd);
    bus.phy_rx_dv_i = dv; bus.phy_rx_er_i = er; bus.phy_rxd_i = rxd;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_fcnt = 16'h0000; m_ecnt = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    bus.phy_rx_dv_i = 1'b0; bus.phy_rx_er_i = 1'b0; bus.phy_rxd_i = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.frame",   32'(bus.mii_rx_frame_o),         32'd0);
    chk("rst.byte",    32'(bus.mii_rx_byte_received_o), 32'd0);
    chk("rst.data",    32'(bus.mii_rx_data_o),          32'h00);
    chk("rst.error",   32'(bus.mii_rx_error_o),         32'd0);
    chk("rst.dribble", 32'(bus.dribble_o),              32'd0);
    chk("rst.fc",      32'(bus.false_carrier_o),        32'd0);
    chk("rst.fcnt",    32'(bus.frame_count_o),          32'd0);
    chk("rst.ecnt",    32'(bus.error_count_o),          32'd0);
    rst = 1'b0;

    // Long preamble, SFD, four data nibbles.
    repeat (15) nib(4'h5);
    nib(4'hD); nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4); idle(3);
    run_episode("good");
    want = '{8'hD5, 8'h21, 8'h43};
    chk_bytes("good");
    chk("good.fcnt", 32'(bus.frame_count_o), 32'd1);
    chk("good.ecnt", 32'(bus.error_count_o), 32'd0);

    // Same frame, RX_ER on the second data nibble.
    repeat (15) nib(4'h5);
    nib(4'hD); nib(4'h1); add(1'b1, 1'b1, 4'h2); nib(4'h3); nib(4'h4); idle(3);
    run_episode("er_mid");
    chk_bytes("er_mid");
    chk("er_mid.ecnt", 32'(bus.error_count_o), 32'd1);

    // Three data nibbles: one byte plus a dribble nibble.
    nib(4'h5); nib(4'h5); nib(4'hD); nib(4'h1); nib(4'h2); nib(4'h3); idle(3);
    run_episode("odd");
    want = '{8'hD5, 8'h21};
    chk_bytes("odd");
    chk("odd.dribbles", 32'(n_drib), 32'd1);
    chk("odd.ecnt", 32'(bus.error_count_o), 32'd1);

    // Carrier without preamble.
    nib(4'hA); nib(4'hA); nib(4'hA); idle(3);
    run_episode("drain");
    chk("drain.nbytes", 32'(got.size()), 32'd0);
    chk("drain.ecnt", 32'(bus.error_count_o), 32'd2);
    chk("drain.fcnt", 32'(bus.frame_count_o), 32'd3);

    // False carrier and near misses.
    add(1'b0, 1'b1, 4'hE); add(1'b0, 1'b0, 4'hE); add(1'b0, 1'b1, 4'hF);
    add(1'b0, 1'b1, 4'hE); idle(2);
    run_episode("fc");
    chk("fc.pulses", 32'(n_fc), 32'd2);
    chk("fc.ecnt", 32'(bus.error_count_o), 32'd4);

    // RX_ER together with DV falling.
    nib(4'h5); nib(4'hD); nib(4'h1); nib(4'h2); add(1'b0, 1'b1, 4'h0); idle(2);
    run_episode("er_fall");
    chk("er_fall.ecnt", 32'(bus.error_count_o), 32'd5);

    // Back-to-back frames with no idle gap.
    nib(4'h5); nib(4'hD); nib(4'h7); nib(4'h8); idle(1);
    run_episode("b2b_a");
    nib(4'h5); nib(4'h5); nib(4'hD); nib(4'h9); nib(4'hA); idle(2);
    run_episode("b2b_b");
    want = '{8'hD5, 8'hA9};
    chk_bytes("b2b_b");
    chk("b2b.fcnt", 32'(bus.frame_count_o), 32'd6);

    // Preamble broken by RX_ER, by a stray nibble, and a preamble-only burst.
    nib(4'h5); nib(4'h5); add(1'b1, 1'b1, 4'h5); nib(4'h5); idle(2);
    run_episode("pre_er");
    nib(4'h5); nib(4'h7); nib(4'h7); idle(2);
    run_episode("pre_bad");
    nib(4'h5); nib(4'h5); nib(4'h5); idle(2);
    run_episode("pre_only");
    chk("pre.ecnt", 32'(bus.error_count_o), 32'd7);
    chk("pre.fcnt", 32'(bus.frame_count_o), 32'd6);

    // Reset in the middle of a frame, released while DV=1 on a non-preamble nibble.
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    chk("mid.frame_up", 32'(bus.mii_rx_frame_o), 32'd1);
    chk("mid.sfd_data", 32'(bus.mii_rx_data_o), 32'hD5);
    drive(1'b1, 1'b0, 4'h1);
    bus.phy_rxd_i = 4'hA;
    #2 rst = 1'b1;
    #1;
    chk("mid.async_frame", 32'(bus.mii_rx_frame_o), 32'd0);
    chk("mid.async_data",  32'(bus.mii_rx_data_o),  32'h00);
    chk("mid.async_fcnt",  32'(bus.frame_count_o),  32'd0);
    chk("mid.async_ecnt",  32'(bus.error_count_o),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    nib(4'hA); nib(4'hA); idle(2);
    run_episode("rst_drain");
    chk("rst_drain.ecnt", 32'(bus.error_count_o), 32'd1);
    chk("rst_drain.fcnt", 32'(bus.frame_count_o), 32'd0);

    // Reset released while DV=1 on a preamble nibble: frame proceeds normally.
    bus.phy_rx_dv_i = 1'b1; bus.phy_rx_er_i = 1'b0; bus.phy_rxd_i = 4'h5;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    nib(4'h5); nib(4'h5); nib(4'hD); nib(4'h3); nib(4'h4); idle(2);
    run_episode("rst_pre");
    want = '{8'hD5, 8'h43};
    chk_bytes("rst_pre");
    chk("rst_pre.fcnt", 32'(bus.frame_count_o), 32'd1);

    // Fill the error counter with false carriers, then confirm it saturates.
    while (m_ecnt != 16'hFFFF) begin
      add(1'b0, 1'b1, 4'hE);
      run_episode("fill");
    end
    chk("sat.full", 32'(bus.error_count_o), 32'hFFFF);
    nib(4'hA); idle(2);
    run_episode("sat_drain");
    chk("sat.after_drain", 32'(bus.error_count_o), 32'hFFFF);

    // Preload the frame counter to its top value, then one good frame wraps it.
    force dut.frame_count_d = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_count_d;
    m_fcnt = 16'hFFFF;
    chk("wrap.preload", 32'(bus.frame_count_o), 32'hFFFF);
    @(negedge clk);
    nib(4'h5); nib(4'hD); nib(4'h1); nib(4'h2); idle(2);
    run_episode("wrap");
    want = '{8'hD5, 8'h21};
    chk_bytes("wrap");
    chk("wrap.fcnt", 32'(bus.frame_count_o), 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
